// File: rtl/arb_pkg.sv
// arb_pkg: shared arbiter states, default master count and a clog2 helper
package arb_pkg;
  localparam int DEFAULT_NUM_MASTERS = 4;
  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    GRANT        = 2'b01,
    RELEASE      = 2'b10,
    WAIT_MEM_LOW = 2'b11
  } state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/bus_arbiter_rr_if.sv
// bus_arbiter_rr_if: rq/bus_ready in, grant/grant_valid/grant_id/busy/timeout out; master = cores+bus side, slave = arbiter
interface bus_arbiter_rr_if #(
  parameter int NUM_MASTERS = arb_pkg::DEFAULT_NUM_MASTERS,
  parameter int ID_W = 2
);
  logic [NUM_MASTERS-1:0] rq;
  logic bus_ready;
  logic [NUM_MASTERS-1:0] grant;
  logic grant_valid;
  logic [ID_W-1:0] grant_id;
  logic busy;
  logic timeout;
  modport master (output rq, bus_ready, input grant, grant_valid, grant_id, busy, timeout);
  modport slave (input rq, bus_ready, output grant, grant_valid, grant_id, busy, timeout);
endinterface

// File: rtl/rr_priority_select.sv
// rr_priority_select: first set rq bit at or above pointer, wrapping; winner index and found flag
module rr_priority_select #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] rq,
  input  logic [W-1:0] pointer,
  output logic [W-1:0] winner,
  output logic         found
);
  logic [N-1:0] rot;
  int off;
  assign rot = N'({rq, rq} >> pointer);
  assign found = |rq;
  always_comb begin
    off = 0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) off = i;
    winner = W'((int'(pointer) + off) % N);
  end
endmodule

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: N-master round-robin bus arbiter with release/mem-low phases; HOLD_TIMEOUT_EN adds forced release after MAX_HOLD cycles
module bus_arbiter_rr import arb_pkg::*; #(
  parameter int NUM_MASTERS = DEFAULT_NUM_MASTERS,
  parameter int ID_W = 2,
  parameter int MAX_HOLD = 64
) (
  input logic clk,
  input logic reset,
  bus_arbiter_rr_if.slave bus
);
  state_t state, state_n;
  logic [NUM_MASTERS-1:0] grant_n, eligible;
  logic [ID_W-1:0] id_n, ptr, ptr_n, ptr_inc, winner;
  logic found, to_n, drop;
`ifdef HOLD_TIMEOUT_EN
  localparam int CNT_W = clog2(MAX_HOLD + 1);
  logic [CNT_W-1:0] hold_cnt;
  logic [NUM_MASTERS-1:0] blocked;
  assign eligible = bus.rq & ~blocked;
  assign to_n = state == GRANT && bus.rq[bus.grant_id] && hold_cnt == CNT_W'(MAX_HOLD - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hold_cnt <= '0;
      blocked <= '0;
    end else begin
      hold_cnt <= state != GRANT ? '0 : hold_cnt == CNT_W'(MAX_HOLD) ? hold_cnt : hold_cnt + 1'b1;
      blocked <= (blocked & bus.rq) | (to_n ? bus.grant : '0);
    end
`else
  assign eligible = bus.rq;
  assign to_n = 1'b0;
`endif
  rr_priority_select #(.N(NUM_MASTERS), .W(ID_W)) u_sel (
    .rq(eligible),
    .pointer(ptr),
    .winner(winner),
    .found(found)
  );
  assign ptr_inc = bus.grant_id == ID_W'(NUM_MASTERS - 1) ? '0 : bus.grant_id + 1'b1;
  assign drop = !bus.rq[bus.grant_id] || to_n;
  always_comb begin
    state_n = state;
    grant_n = bus.grant;
    id_n = bus.grant_id;
    ptr_n = ptr;
    case (state)
      IDLE: if (found && !bus.bus_ready) begin
        state_n = GRANT;
        grant_n = NUM_MASTERS'(1) << winner;
        id_n = winner;
      end
      GRANT: if (drop) begin
        state_n = RELEASE;
        grant_n = '0;
        id_n = '0;
        ptr_n = ptr_inc;
      end
      RELEASE: state_n = WAIT_MEM_LOW;
      WAIT_MEM_LOW: state_n = bus.bus_ready ? WAIT_MEM_LOW : IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      bus.grant <= '0;
      bus.grant_valid <= 1'b0;
      bus.grant_id <= '0;
      bus.busy <= 1'b0;
      bus.timeout <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      bus.grant <= grant_n;
      bus.grant_valid <= |grant_n;
      bus.grant_id <= id_n;
      bus.busy <= state_n != IDLE;
      bus.timeout <= to_n;
    end
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: directed and random stimulus against a cycle-level round-robin reference model
module tb_bus_arbiter_rr;
  localparam int N = 4;
  localparam int W = 2;
`ifdef HOLD_TIMEOUT_EN
  localparam int MH = 8;
`else
  localparam int MH = 64;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  bus_arbiter_rr_if #(.NUM_MASTERS(N), .ID_W(W)) bif ();
  bus_arbiter_rr #(.NUM_MASTERS(N), .ID_W(W), .MAX_HOLD(MH)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bif)
  );
  int n_cmp = 0;
  int n_bad = 0;
  int m_owner, m_ptr, m_phase, m_held;
  logic [N-1:0] m_blocked;
  logic m_to;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_owner = -1;
    m_ptr = 0;
    m_phase = 0;
    m_held = 0;
    m_blocked = '0;
    m_to = 1'b0;
  endtask
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  task automatic model_step(input logic [N-1:0] r, input logic br);
    logic [N-1:0] keep;
    int w;
    keep = m_blocked & r;
    m_to = 1'b0;
    if (m_owner >= 0) begin
      m_held++;
      if (!r[m_owner]) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
        m_phase = 1;
      end
`ifdef HOLD_TIMEOUT_EN
      else if (m_held == MH) begin
        keep[m_owner] = 1'b1;
        m_to = 1'b1;
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
        m_phase = 1;
      end
`endif
    end else if (m_phase == 1) m_phase = 2;
    else if (m_phase == 2) begin
      if (!br) m_phase = 0;
    end else if (!br) begin
      w = pick(r & ~m_blocked, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_held = 0;
      end
    end
    m_blocked = keep;
  endtask
  task automatic expect_outputs(input string tag);
    logic [N-1:0] eg;
    eg = m_owner >= 0 ? N'(1) << m_owner : '0;
    check({tag, ".grant"}, 32'(bif.grant), 32'(eg));
    check({tag, ".grant_valid"}, 32'(bif.grant_valid), 32'(m_owner >= 0));
    check({tag, ".grant_id"}, 32'(bif.grant_id), m_owner >= 0 ? 32'(m_owner) : 32'd0);
    check({tag, ".busy"}, 32'(bif.busy), 32'(m_owner >= 0 || m_phase != 0));
    check({tag, ".timeout"}, 32'(bif.timeout), 32'(m_to));
    check({tag, ".onehot"}, 32'($onehot0(bif.grant)), 32'd1);
  endtask
  task automatic drive(input logic [N-1:0] r, input logic br, input string tag);
    bif.rq = r;
    bif.bus_ready = br;
    model_step(r, br);
    @(negedge clk);
    expect_outputs(tag);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bif.rq = '0;
    bif.bus_ready = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    expect_outputs("reset");
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && bif.busy; i++) drive('0, 1'b0, "drain");
    check("drain.idle", 32'(bif.busy), 32'd0);
  endtask
  task automatic serve(input logic [N-1:0] r, output int id);
    id = -1;
    for (int i = 0; i < 20 && id < 0; i++) begin
      drive(r, 1'b0, "serve");
      if (bif.grant_valid) id = int'(bif.grant_id);
    end
    check("serve.granted", 32'(id >= 0), 32'd1);
    drain();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int id, pulses;
    int order[$];
    logic [N-1:0] r;
    logic br;
    bif.rq = '0;
    bif.bus_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    expect_outputs("reset");
    drive(4'b0001, 1'b0, "t1");
    check("t1.first_grant", 32'(bif.grant), 32'h1);
    check("t1.first_id", 32'(bif.grant_id), 32'd0);
    drive(4'b0001, 1'b0, "t1");
    drive(4'b0000, 1'b1, "t1");
    check("t1.release_grant", 32'(bif.grant), 32'h0);
    drive(4'b0000, 1'b1, "t1");
    drive(4'b0000, 1'b1, "t1");
    check("t1.wait_busy", 32'(bif.busy), 32'd1);
    drive(4'b0000, 1'b0, "t1");
    check("t1.idle_busy", 32'(bif.busy), 32'd0);
    do_reset();
    for (int g = 0; g < 5; g++) begin
      for (int i = 0; i < 10 && !bif.grant_valid; i++) drive(4'b1111, 1'b0, "t2");
      check("t2.granted", 32'(bif.grant_valid), 32'd1);
      order.push_back(int'(bif.grant_id));
      repeat (4) drive(4'b1111, 1'b0, "t2");
      drive(4'b1111 & ~(N'(1) << bif.grant_id), 1'b0, "t2");
    end
    for (int g = 0; g < 5; g++) check("t2.order", 32'(order[g]), 32'(g % N));
    drain();
    do_reset();
    serve(4'b0100, id);
    check("t3.setup", 32'(id), 32'd2);
    serve(4'b0101, id);
    check("t3.wrap", 32'(id), 32'd0);
    serve(4'b0101, id);
    check("t3.next", 32'(id), 32'd2);
    for (int i = 0; i < 10; i++) begin
      drive(4'b0001, 1'b1, "t4");
      check("t4.held_off", 32'(bif.grant_valid), 32'd0);
    end
    drive(4'b0001, 1'b0, "t4");
    check("t4.grant", 32'(bif.grant), 32'h1);
    drive(4'b1110, 1'b1, "t5");
    for (int i = 0; i < 7; i++) begin
      drive(4'b1110, 1'b1, "t5");
      check("t5.busy", 32'(bif.busy), 32'd1);
      check("t5.no_grant", 32'(bif.grant_valid), 32'd0);
    end
    drive(4'b1110, 1'b0, "t5");
    drive(4'b1110, 1'b0, "t5");
    check("t5.next_owner", 32'(bif.grant_id), 32'd1);
    drain();
`ifdef HOLD_TIMEOUT_EN
    do_reset();
    pulses = 0;
    repeat (3 * MH + 10) begin
      drive(4'b0011, 1'b0, "to");
      pulses += int'(bif.timeout);
    end
    check("to.pulses", 32'(pulses), 32'd2);
    check("to.blocked", 32'(bif.grant_valid), 32'd0);
    drive(4'b0010, 1'b0, "to");
    for (int i = 0; i < 10 && !bif.grant_valid; i++) drive(4'b0011, 1'b0, "to");
    check("to.regrant", 32'(bif.grant), 32'h1);
`else
    pulses = 0;
    repeat (MH + 4) begin
      drive(4'b0001, 1'b0, "hold");
      pulses += int'(bif.timeout);
    end
    check("hold.no_timeout", 32'(pulses), 32'd0);
    check("hold.kept", 32'(bif.grant), 32'h1);
`endif
    do_reset();
    r = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      br = $urandom_range(0, 3) == 0;
      drive(r, br, "rand");
    end
    do_reset();
    for (int i = 0; i < 10 && !bif.grant_valid; i++) drive(4'b1000, 1'b0, "t7");
    check("t7.granted", 32'(bif.grant), 32'h8);
    #2 reset = 1'b1;
    #1;
    check("t7.async_grant", 32'(bif.grant), 32'h0);
    check("t7.async_valid", 32'(bif.grant_valid), 32'd0);
    check("t7.async_busy", 32'(bif.busy), 32'd0);
    bif.rq = '0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    expect_outputs("t7.after");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- N-master round-robin arbiter for one shared memory bus (instruction or data). One instance per bus.
- Generalises the single-core RQ/GRANT handshake to NUM_MASTERS cores, with fair rotation and a memory-ready release phase.
- Sits between the per-core arbitration sub-modules (RQ out, GRANT in) and the shared bus / memory ready line.

Parameters:
- NUM_MASTERS, 4, number of requesting cores; legal range 2..16.
- ID_W, 2, width of grant_id; must be ≥ clog2(NUM_MASTERS).
- MAX_HOLD, 64, maximum cycles a grant may be held; used only when HOLD_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rq  in  NUM_MASTERS  per-master bus request; bit i from core i.
- bus_ready  in  1  memory ready/valid from shared bus.
- grant  out  NUM_MASTERS  one-hot (or zero) bus grant.
- grant_valid  out  1  high when any grant bit is set.
- grant_id  out  ID_W  index of current owner; 0 when grant_valid is 0.
- busy  out  1  high in every state except IDLE.
- timeout  out  1  one-cycle pulse on forced release (HOLD_TIMEOUT_EN only; tied 0 otherwise).

Behaviour:
- All outputs are registered.
- Reset:
  - state=IDLE, grant=0, grant_valid=0, grant_id=0, busy=0, timeout=0.
  - rr pointer=0, hold counter=0.
  - Reset asserted mid-grant clears grant asynchronously; no release phase.
- States (2-bit): IDLE=00, GRANT=01, RELEASE=10, WAIT_MEM_LOW=11.
- IDLE:
  - If |rq and bus_ready==0 at a rising edge, pick a winner: the first set rq bit scanning from pointer upward, wrapping at NUM_MASTERS-1 → 0.
  - At that same edge: grant[winner]←1, grant_id←winner, state←GRANT.
  - Latency: rq sampled high → grant visible one cycle later.
  - If bus_ready==1, stay in IDLE; requests are held off until memory is idle.
- GRANT:
  - Grant is held while rq[owner]==1. Other masters' rq are ignored.
  - Hold counter increments each cycle, saturating at MAX_HOLD.
  - rq[owner] sampled 0 → grant←0, pointer←(owner+1) mod NUM_MASTERS, state←RELEASE.
- RELEASE:
  - One dead cycle with grant=0; busy stays 1.
  - Unconditionally → WAIT_MEM_LOW.
- WAIT_MEM_LOW:
  - Stays while bus_ready==1.
  - bus_ready sampled 0 → IDLE and hold counter←0.
  - A new grant can be issued in the cycle after IDLE is entered. Minimum back-to-back gap between grants is 3 cycles.
- Simultaneous requests: resolved strictly by pointer order, never fixed priority.
- Request dropped before grant: no grant is issued and the pointer does not move.
- Owner re-raises rq during RELEASE or WAIT_MEM_LOW: treated as a new request in IDLE, behind the rotated pointer.
- Pointer wrap: owner NUM_MASTERS-1 → pointer 0.
- Invariant: grant is one-hot or zero at all times.

Optional Feature:
- Macro HOLD_TIMEOUT_EN.
- Defined: when the hold counter reaches MAX_HOLD in GRANT while rq[owner] is still 1:
  - grant←0, timeout pulses high for one cycle, pointer←owner+1, state←RELEASE.
  - The owner re-enters arbitration only after dropping and re-raising rq.
- Not defined: no hold counter; a grant is held indefinitely; timeout is tied 0.

Decomposition:
- Package arb_pkg: state localparams (IDLE/GRANT/RELEASE/WAIT_MEM_LOW), a clog2 function, and the default NUM_MASTERS.
- Sub-module rr_priority_select: combinational; inputs rq and pointer; outputs winner index and found flag. Reused by future arbiters.
- FSM, pointer, counter and output registers stay in bus_arbiter_rr.

Test Plan:
- Reset, then rq=4'b0001 with bus_ready=0 → grant=0001 and grant_id=0 one cycle after rq is sampled. Drop rq → grant=0 next edge, then RELEASE, then WAIT_MEM_LOW, then IDLE once bus_ready=0.
- rq=4'b1111 held, each owner dropping rq after 5 cycles → grant order 0,1,2,3,0. grant_id matches each time, and grant is never multi-hot.
- Pointer=3, rq=4'b0101 → master 0 granted (wrap); next arbitration with the same rq → master 2.
- rq=0001 while bus_ready=1 for 10 cycles → no grant. bus_ready falls → grant=0001 one cycle later.
- Owner releases while bus_ready stays 1 for 7 cycles → state stays WAIT_MEM_LOW and busy=1 throughout; other rq are not granted until bus_ready=0.
- HOLD_TIMEOUT_EN with MAX_HOLD=8 and rq=0011 held forever → grant 0 revoked after 8 cycles with timeout pulse=1, then master 1 granted. Master 0 is not re-granted until its rq toggles. Reset asserted mid-grant → grant=0 immediately.
